cond_flag_unit: RTL and testbench
=================================

# cond_flag_unit

Conditional-execution and status-flag stage sitting directly downstream of the instruction decoder (control unit) and beside the ALU. Holds the architectural NZCV register and evaluates all 16 ARM condition codes against it. Gates the decoder's raw write/branch enables into the final `PCSrc`/`RegWrite`/`MemWrite` seen by the datapath, and keeps saturating executed/skipped instruction counters for debug.

## Interface
- `CNT_W`, 16: width of each debug counter.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  decoder presents a valid instruction this cycle.
- `stall`  in  1  datapath freeze; instruction not accepted this cycle.
- `Cond`  in  4  instruction condition field [31:28].
- `ALUFlags`  in  4  {N,Z,C,V} produced by the ALU this cycle.
- `PCS`  in  1  raw branch/PC-write request from decoder.
- `RegW`  in  2  raw register-write request (bit1 = Rd/R14 port, bit0 = result port).
- `MemW`  in  1  raw memory-write request.
- `FlagW`  in  2  flag-write request: [1] updates N,Z; [0] updates C,V.
- `NoWrite`  in  1  compare-class instruction; suppresses register write.
- `PCSrc`  out  1  gated branch select.
- `RegWrite`  out  2  gated register-write enables.
- `MemWrite`  out  1  gated memory-write enable.
- `CondEx`  out  1  condition result against registered flags.
- `Flags`  out  4  current NZCV register {N,Z,C,V}.
- `exec_cnt`  out  CNT_W  accepted instructions whose condition passed.
- `skip_cnt`  out  CNT_W  accepted instructions whose condition failed.

## Operation
- accept = `reset` high & `instr_valid` & ~`stall`.
- CondEx from registered `Flags` (never from `ALUFlags`): 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0 (never executes).
- go = accept & CondEx.
- `PCSrc` = `PCS` & go; `MemWrite` = `MemW` & go; `RegWrite` = `RegW` & {2{go & ~NoWrite}}.
- Flag update on edge when go: `FlagW[1]` -> N,Z <= `ALUFlags[3:2]`; `FlagW[0]` -> C,V <= `ALUFlags[1:0]`; unselected pair holds.
- Failed condition: no flag update, all gated outputs 0.
- Counters: on accept, exec_cnt+1 if CondEx else skip_cnt+1; each saturates at 2^CNT_W-1, no wrap.
- Stall or ~instr_valid: gated outputs 0, no flag or counter change; `CondEx` still driven.

## Timing
- Gated outputs and `CondEx`: combinational, zero latency from inputs/`Flags`.
- Flag update visible on `Flags` and to the next instruction's condition one cycle after the writing instruction (no same-cycle forwarding).
- Reset values: `Flags`=0000, `exec_cnt`=0, `skip_cnt`=0; `PCSrc`, `RegWrite`, `MemWrite` forced 0 while `reset` low; `CondEx` follows `Cond` against 0000.
- Reset asserted mid-operation: state clears immediately (asynchronous); the in-flight instruction produces no writes and no flag update.
- Simultaneous FlagW pair writes: both pairs updated in the same edge.
- Instruction whose own condition reads flags it writes: evaluates old flags, writes new.

## Structure
- Shared package: condition-code localparams COND_EQ..COND_NV, flag bit indices FLAG_N=3/Z=2/C=1/V=0, FlagW bit meanings FLAGW_NZ=1/FLAGW_CV=0.
- One sub-module `cond_check`: purely combinational {Cond, Flags} -> CondEx; top holds registers, gating, counters.

## Test plan
- Reset release, Cond=0000, PCS=1, valid -> PCSrc=0, next cycle skip_cnt=1, exec_cnt=0, Flags=0000.
- Cond=1110, FlagW=11, NoWrite=1, RegW=11, ALUFlags=0100 -> RegWrite=00, next cycle Flags=0100; then Cond=0000, PCS=1 -> PCSrc=1.
- Flags=0100, FlagW=01, ALUFlags=1011 -> Flags=0111; then Cond=1000 (HI) -> CondEx=0; Cond=1001 (LS) -> CondEx=1.
- Flags=0100, Cond=0001, MemW=1, FlagW=11, ALUFlags=0000 -> MemWrite=0, Flags remain 0100, skip_cnt increments.
- Cond=1110, MemW=1, stall=1 -> MemWrite=0, counters and Flags unchanged; deassert stall -> MemWrite=1.
- CNT_W=4: 20 consecutive accepted AL instructions -> exec_cnt=15 (saturated); reset low mid-sequence -> counters 0 immediately, RegWrite=00.

Source files
------------

// File: rtl/cond_flag_unit_pkg.sv
// Shared definitions for the conditional-execution / status-flag stage.
//   - COND_*   : 4-bit ARM condition-code encodings (instruction bits [31:28])
//   - FLAG_*   : bit positions of N, Z, C, V inside the {N,Z,C,V} flag vector
//   - FLAGW_*  : bit positions inside the decoder's FlagW request
package cond_flag_unit_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_flag_unit_cond_check.sv
// cond_check: purely combinational condition-code evaluator.
//   Cond   in  4  instruction condition field
//   Flags  in  4  {N,Z,C,V} to test against
//   CondEx out 1  1 when the condition holds
module cond_check
    import cond_flag_unit_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;
    logic ge;

    assign flag_n = Flags[FLAG_N];
    assign flag_z = Flags[FLAG_Z];
    assign flag_c = Flags[FLAG_C];
    assign flag_v = Flags[FLAG_V];
    assign ge     = (flag_n == flag_v);

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = flag_z;
            COND_NE: CondEx = ~flag_z;
            COND_CS: CondEx = flag_c;
            COND_CC: CondEx = ~flag_c;
            COND_MI: CondEx = flag_n;
            COND_PL: CondEx = ~flag_n;
            COND_VS: CondEx = flag_v;
            COND_VC: CondEx = ~flag_v;
            COND_HI: CondEx = flag_c & ~flag_z;
            COND_LS: CondEx = ~flag_c | flag_z;
            COND_GE: CondEx = ge;
            COND_LT: CondEx = ~ge;
            COND_GT: CondEx = ~flag_z & ge;
            COND_LE: CondEx = flag_z | ~ge;
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = 1'b0;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: holds the NZCV register, evaluates the instruction's
// condition against it and gates the decoder's raw enables.
//   clk, reset (async active-low)
//   instr_valid, stall           : instruction accept handshake
//   Cond, ALUFlags               : condition field and ALU {N,Z,C,V}
//   PCS, RegW, MemW, FlagW, NoWrite : raw decoder requests
//   PCSrc, RegWrite, MemWrite    : gated enables (combinational)
//   CondEx                       : condition result against registered Flags
//   Flags                        : architectural {N,Z,C,V}
//   exec_cnt, skip_cnt           : saturating debug counters
module cond_flag_unit
    import cond_flag_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic             stall,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic             PCS,
    input  logic [1:0]       RegW,
    input  logic             MemW,
    input  logic [1:0]       FlagW,
    input  logic             NoWrite,
    output logic             PCSrc,
    output logic [1:0]       RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]       flags_reg;
    logic [3:0]       flags_next;
    logic [CNT_W-1:0] exec_cnt_reg;
    logic [CNT_W-1:0] exec_cnt_next;
    logic [CNT_W-1:0] skip_cnt_reg;
    logic [CNT_W-1:0] skip_cnt_next;
    logic             accept;
    logic             go;

    // Condition is always evaluated against the registered flags, so an
    // instruction that writes flags sees the old values for its own test.
    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (flags_reg),
        .CondEx (CondEx)
    );

    // reset is folded in so the gated outputs are forced low while held in reset.
    assign accept = reset & instr_valid & ~stall;
    assign go     = accept & CondEx;

    assign PCSrc    = PCS & go;
    assign MemWrite = MemW & go;
    assign RegWrite = RegW & {2{go & ~NoWrite}};

    // Each FlagW bit owns one flag pair; an unselected pair keeps its value.
    assign flags_next[FLAG_N:FLAG_Z] = (go & FlagW[FLAGW_NZ]) ? ALUFlags[FLAG_N:FLAG_Z]
                                                               : flags_reg[FLAG_N:FLAG_Z];
    assign flags_next[FLAG_C:FLAG_V] = (go & FlagW[FLAGW_CV]) ? ALUFlags[FLAG_C:FLAG_V]
                                                               : flags_reg[FLAG_C:FLAG_V];

    always_comb begin
        exec_cnt_next = exec_cnt_reg;
        skip_cnt_next = skip_cnt_reg;
        if (accept) begin
            if (CondEx) begin
                if (exec_cnt_reg != CNT_MAX) exec_cnt_next = exec_cnt_reg + 1'b1;
            end else begin
                if (skip_cnt_reg != CNT_MAX) skip_cnt_next = skip_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_reg    <= 4'b0000;
            exec_cnt_reg <= '0;
            skip_cnt_reg <= '0;
        end else begin
            flags_reg    <= flags_next;
            exec_cnt_reg <= exec_cnt_next;
            skip_cnt_reg <= skip_cnt_next;
        end
    end

    assign Flags    = flags_reg;
    assign exec_cnt = exec_cnt_reg;
    assign skip_cnt = skip_cnt_reg;

endmodule

// File: tb/tb_cond_flag_unit.sv
module tb_cond_flag_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        stall;
    logic [3:0]  Cond;
    logic [3:0]  ALUFlags;
    logic        PCS;
    logic [1:0]  RegW;
    logic        MemW;
    logic [1:0]  FlagW;
    logic        NoWrite;

    logic        PCSrc;
    logic [1:0]  RegWrite;
    logic        MemWrite;
    logic        CondEx;
    logic [3:0]  Flags;
    logic [15:0] exec_cnt;
    logic [15:0] skip_cnt;

    logic        PCSrc4;
    logic [1:0]  RegWrite4;
    logic        MemWrite4;
    logic        CondEx4;
    logic [3:0]  Flags4;
    logic [3:0]  exec_cnt4;
    logic [3:0]  skip_cnt4;

    always #5 clk = ~clk;

    cond_flag_unit #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .stall(stall),
        .Cond(Cond), .ALUFlags(ALUFlags), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .FlagW(FlagW), .NoWrite(NoWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags),
        .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
    );

    cond_flag_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .stall(stall),
        .Cond(Cond), .ALUFlags(ALUFlags), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .FlagW(FlagW), .NoWrite(NoWrite), .PCSrc(PCSrc4), .RegWrite(RegWrite4),
        .MemWrite(MemWrite4), .CondEx(CondEx4), .Flags(Flags4),
        .exec_cnt(exec_cnt4), .skip_cnt(skip_cnt4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [3:0] m_flags;
    int         m_exec, m_skip, m_exec4, m_skip4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Condition codes come in complementary pairs: bits [3:1] pick the base
    // predicate, bit 0 inverts it.  1111 is the lone exception (never).
    function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    function automatic int sat_inc(input int x, input int maxv);
        return (x >= maxv) ? maxv : x + 1;
    endfunction

    // Advance the reference by one clock edge using the current inputs.
    task automatic model_edge();
        logic pass;
        if (reset && instr_valid && !stall) begin
            pass = model_cond(Cond, m_flags);
            if (pass) begin
                m_exec  = sat_inc(m_exec, 65535);
                m_exec4 = sat_inc(m_exec4, 15);
                if (FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
                if (FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
            end else begin
                m_skip  = sat_inc(m_skip, 65535);
                m_skip4 = sat_inc(m_skip4, 15);
            end
        end
    endtask

    task automatic check_comb_model();
        logic pass, go;
        pass = model_cond(Cond, m_flags);
        go   = reset && instr_valid && !stall && pass;
        chk("CondEx",   {31'd0, CondEx},   {31'd0, pass});
        chk("PCSrc",    {31'd0, PCSrc},    {31'd0, go && PCS});
        chk("MemWrite", {31'd0, MemWrite}, {31'd0, go && MemW});
        chk("RegWrite", {30'd0, RegWrite}, {30'd0, (go && !NoWrite) ? RegW : 2'b00});
    endtask

    task automatic check_state_model();
        chk("Flags",     {28'd0, Flags},     {28'd0, m_flags});
        chk("exec_cnt",  {16'd0, exec_cnt},  m_exec);
        chk("skip_cnt",  {16'd0, skip_cnt},  m_skip);
        chk("exec_cnt4", {28'd0, exec_cnt4}, m_exec4);
        chk("skip_cnt4", {28'd0, skip_cnt4}, m_skip4);
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0; stall = 1'b0; Cond = 4'hE; ALUFlags = 4'h0;
        PCS = 1'b0; RegW = 2'b00; MemW = 1'b0; FlagW = 2'b00; NoWrite = 1'b0;
    endtask

    typedef struct {
        logic       valid;
        logic       stl;
        logic [3:0] cond;
        logic [3:0] alu;
        logic       pcs;
        logic [1:0] regw;
        logic       memw;
        logic [1:0] flagw;
        logic       nowr;
        logic       e_condex;
        logic       e_pcsrc;
        logic [1:0] e_regw;
        logic       e_memw;
        logic [3:0] e_flags;
        int         e_exec;
        int         e_skip;
    } vec_t;

    vec_t tbl [15];

    initial begin
        // valid stall cond alu pcs regw memw flagw nowr | condex pcsrc regw memw flags exec skip
        tbl[0]  = '{1'b1,1'b0,4'h0,4'h0,1'b1,2'b00,1'b0,2'b00,1'b0, 1'b0,1'b0,2'b00,1'b0,4'h0,0,1};
        tbl[1]  = '{1'b1,1'b0,4'hE,4'h4,1'b0,2'b11,1'b0,2'b11,1'b1, 1'b1,1'b0,2'b00,1'b0,4'h4,1,1};
        tbl[2]  = '{1'b1,1'b0,4'h0,4'h0,1'b1,2'b00,1'b0,2'b00,1'b0, 1'b1,1'b1,2'b00,1'b0,4'h4,2,1};
        tbl[3]  = '{1'b1,1'b0,4'hE,4'hB,1'b0,2'b00,1'b0,2'b01,1'b0, 1'b1,1'b0,2'b00,1'b0,4'h7,3,1};
        tbl[4]  = '{1'b1,1'b0,4'h8,4'h0,1'b1,2'b00,1'b0,2'b00,1'b0, 1'b0,1'b0,2'b00,1'b0,4'h7,3,2};
        tbl[5]  = '{1'b1,1'b0,4'h9,4'h0,1'b1,2'b00,1'b0,2'b00,1'b0, 1'b1,1'b1,2'b00,1'b0,4'h7,4,2};
        tbl[6]  = '{1'b1,1'b0,4'hE,4'h0,1'b0,2'b00,1'b0,2'b01,1'b0, 1'b1,1'b0,2'b00,1'b0,4'h4,5,2};
        tbl[7]  = '{1'b1,1'b0,4'h1,4'h0,1'b0,2'b00,1'b1,2'b11,1'b0, 1'b0,1'b0,2'b00,1'b0,4'h4,5,3};
        tbl[8]  = '{1'b1,1'b1,4'hE,4'h0,1'b0,2'b00,1'b1,2'b00,1'b0, 1'b1,1'b0,2'b00,1'b0,4'h4,5,3};
        tbl[9]  = '{1'b1,1'b0,4'hE,4'h0,1'b0,2'b00,1'b1,2'b00,1'b0, 1'b1,1'b0,2'b00,1'b1,4'h4,6,3};
        tbl[10] = '{1'b1,1'b0,4'hF,4'h0,1'b0,2'b11,1'b0,2'b00,1'b0, 1'b0,1'b0,2'b00,1'b0,4'h4,6,4};
        tbl[11] = '{1'b1,1'b0,4'hE,4'h0,1'b0,2'b11,1'b0,2'b00,1'b0, 1'b1,1'b0,2'b11,1'b0,4'h4,7,4};
        tbl[12] = '{1'b0,1'b0,4'hE,4'hF,1'b1,2'b11,1'b1,2'b11,1'b0, 1'b1,1'b0,2'b00,1'b0,4'h4,7,4};
        tbl[13] = '{1'b1,1'b0,4'h0,4'h0,1'b1,2'b00,1'b0,2'b11,1'b0, 1'b1,1'b1,2'b00,1'b0,4'h0,8,4};
        tbl[14] = '{1'b1,1'b0,4'h0,4'h0,1'b1,2'b00,1'b0,2'b00,1'b0, 1'b0,1'b0,2'b00,1'b0,4'h0,8,5};

        m_flags = 4'h0; m_exec = 0; m_skip = 0; m_exec4 = 0; m_skip4 = 0;

        // Held in reset: valid branch request must not leak out.
        reset = 1'b0;
        idle_inputs();
        instr_valid = 1'b1; PCS = 1'b1; Cond = 4'h0;
        #1;
        chk("rst_Flags",    {28'd0, Flags},  32'h0);
        chk("rst_exec_cnt", {16'd0, exec_cnt}, 32'h0);
        chk("rst_skip_cnt", {16'd0, skip_cnt}, 32'h0);
        chk("rst_PCSrc",    {31'd0, PCSrc},  32'h0);
        chk("rst_CondEx_EQ", {31'd0, CondEx}, 32'h0);
        Cond = 4'h1;
        #1;
        chk("rst_CondEx_NE", {31'd0, CondEx}, 32'h1);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;

        // Directed table
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            instr_valid = tbl[i].valid; stall = tbl[i].stl; Cond = tbl[i].cond;
            ALUFlags = tbl[i].alu; PCS = tbl[i].pcs; RegW = tbl[i].regw;
            MemW = tbl[i].memw; FlagW = tbl[i].flagw; NoWrite = tbl[i].nowr;
            #1;
            chk($sformatf("tbl%0d_CondEx", i),   {31'd0, CondEx},   {31'd0, tbl[i].e_condex});
            chk($sformatf("tbl%0d_PCSrc", i),    {31'd0, PCSrc},    {31'd0, tbl[i].e_pcsrc});
            chk($sformatf("tbl%0d_RegWrite", i), {30'd0, RegWrite}, {30'd0, tbl[i].e_regw});
            chk($sformatf("tbl%0d_MemWrite", i), {31'd0, MemWrite}, {31'd0, tbl[i].e_memw});
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("tbl%0d_Flags", i),    {28'd0, Flags},    {28'd0, tbl[i].e_flags});
            chk($sformatf("tbl%0d_exec_cnt", i), {16'd0, exec_cnt}, tbl[i].e_exec);
            chk($sformatf("tbl%0d_skip_cnt", i), {16'd0, skip_cnt}, tbl[i].e_skip);
            $display("tbl %0d cond=%h flags=%h exec=%0d skip=%0d", i, tbl[i].cond, Flags, exec_cnt, skip_cnt);
        end

        // 20 accepted AL instructions: 4-bit counter must stick at 15.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            idle_inputs();
            instr_valid = 1'b1; Cond = 4'hE; RegW = 2'b01;
            #1;
            check_comb_model();
            @(posedge clk);
            model_edge();
            #1;
            check_state_model();
            $display("sat %0d exec4=%0d exec=%0d", i, exec_cnt4, exec_cnt);
        end
        chk("sat_exec_cnt4", {28'd0, exec_cnt4}, 32'd15);
        chk("sat_exec_cnt",  {16'd0, exec_cnt},  32'd28);

        // Reset asserted between edges while a flag-writing instruction is in flight.
        @(negedge clk);
        idle_inputs();
        instr_valid = 1'b1; Cond = 4'hE; RegW = 2'b11; FlagW = 2'b11; ALUFlags = 4'hF; MemW = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_exec_cnt",  {16'd0, exec_cnt},  32'h0);
        chk("midrst_skip_cnt",  {16'd0, skip_cnt},  32'h0);
        chk("midrst_exec_cnt4", {28'd0, exec_cnt4}, 32'h0);
        chk("midrst_RegWrite",  {30'd0, RegWrite},  32'h0);
        chk("midrst_MemWrite",  {31'd0, MemWrite},  32'h0);
        chk("midrst_Flags",     {28'd0, Flags},     32'h0);
        chk("midrst_CondEx",    {31'd0, CondEx},    32'h1);
        @(posedge clk);
        #1;
        chk("midrst_Flags_edge", {28'd0, Flags}, 32'h0);
        $display("midrst flags=%h exec=%0d skip=%0d", Flags, exec_cnt, skip_cnt);
        m_flags = 4'h0; m_exec = 0; m_skip = 0; m_exec4 = 0; m_skip4 = 0;
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;

        // Randomized run against the reference
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            instr_valid = ($urandom_range(0, 7) != 0);
            stall       = ($urandom_range(0, 4) == 0);
            Cond        = 4'($urandom);
            ALUFlags    = 4'($urandom);
            PCS         = 1'($urandom);
            RegW        = 2'($urandom);
            MemW        = 1'($urandom);
            FlagW       = 2'($urandom);
            NoWrite     = 1'($urandom);
            #1;
            check_comb_model();
            @(posedge clk);
            model_edge();
            #1;
            check_state_model();
            if (i % 50 == 0)
                $display("rnd %0d cond=%h flags=%h exec=%0d skip=%0d", i, Cond, Flags, exec_cnt, skip_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
